if_id_queue: RTL and testbench

//  - Instruction queue between the FETCH stage (PC generator) and the decode stage.
//  - Captures {pc, instr} pairs from fetch/imem, buffers up to DEPTH entries, and presents them in order to decode.
//  - Uses a valid/ready handshake.
//  - Drives fetch_halt back to FETCH when full.
//  - Branch/jump redirect flushes every buffered entry in one cycle.

---
 rtl/if_id_queue.sv | 93 +++++++++
 tb/tb_if_id_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, instr} pairs with valid/ready on both sides.
// Optional IFID_BUBBLE_NOP_EN presents pc=0 / addi x0,x0,0 on the outputs whenever the queue is empty.
module if_id_queue #(
    parameter int WIDTH = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [ILEN-1:0]            in_instr,
    output logic                       in_ready,
    output logic                       fetch_halt,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [ILEN-1:0]            out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0]  instr_mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             push;
    logic             pop;

    // Status comes only from registered count, so no combinational path from in_valid/out_ready.
    assign in_ready   = (count_reg != FULL_COUNT);
    assign fetch_halt = ~in_ready;
    assign out_valid  = (count_reg != '0);
    assign level      = count_reg;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + ONE_COUNT;
        end else if (pop && !push) begin
            count_next = count_reg - ONE_COUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_reg]    <= in_pc;
            instr_mem[wr_ptr_reg] <= in_instr;
        end
    end

`ifdef IFID_BUBBLE_NOP_EN
    localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

    assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : NOP_INSTR;
`else
    assign out_pc    = pc_mem[rd_ptr_reg];
    assign out_instr = instr_mem[rd_ptr_reg];
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: table-driven vectors plus hand-written reset and streaming sequences.
module tb_if_id_queue;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        fetch_halt;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [1:0]  level;

    int total_checks;
    int passed_checks;

`ifdef IFID_BUBBLE_NOP_EN
    localparam logic [31:0] RST_INSTR = 32'h0000_0013;
`else
    localparam logic [31:0] RST_INSTR = 32'h0000_0000;
`endif

    if_id_queue dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .fetch_halt (fetch_halt),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_ready  (out_ready),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic [1:0]  exp_level;
        logic        exp_ov;
        logic        exp_ir;
        logic        chk_head;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    function automatic vec_t mk(string name, logic rst, logic fl, logic iv, logic [31:0] pc,
                                logic [31:0] instr, logic ordy, logic [1:0] exp_level,
                                logic exp_ov, logic exp_ir, logic chk_head,
                                logic [31:0] exp_pc, logic [31:0] exp_instr);
        vec_t v;
        v.name = name; v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.instr = instr;
        v.ordy = ordy; v.exp_level = exp_level; v.exp_ov = exp_ov; v.exp_ir = exp_ir;
        v.chk_head = chk_head; v.exp_pc = exp_pc; v.exp_instr = exp_instr;
        return v;
    endfunction

    // Instruction word associated with a given PC in this bench.
    function automatic logic [31:0] ins_of(logic [31:0] pc);
        return (pc == 32'h0) ? 32'h0050_0093 : (32'hA500_0000 ^ pc);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic check_status(string name, logic [1:0] exp_level, logic exp_ov, logic exp_ir);
        check({name, ".level"},      32'(level),      32'(exp_level));
        check({name, ".out_valid"},  32'(out_valid),  32'(exp_ov));
        check({name, ".in_ready"},   32'(in_ready),   32'(exp_ir));
        check({name, ".fetch_halt"}, 32'(fetch_halt), 32'(!exp_ir));
    endtask

    task automatic apply(vec_t v);
        reset = v.rst; flush = v.fl; in_valid = v.iv; in_pc = v.pc; in_instr = v.instr;
        out_ready = v.ordy;
        @(posedge clk);
        #1;
        check_status(v.name, v.exp_level, v.exp_ov, v.exp_ir);
        if (v.chk_head) begin
            check({v.name, ".out_pc"},    out_pc,    v.exp_pc);
            check({v.name, ".out_instr"}, out_instr, v.exp_instr);
        end
        $display("vec %-12s rst=%0b fl=%0b iv=%0b pc=%08h ordy=%0b -> level=%0d ov=%0b ir=%0b out_pc=%08h out_instr=%08h",
                 v.name, v.rst, v.fl, v.iv, v.pc, v.ordy, level, out_valid, in_ready, out_pc, out_instr);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

        // Fill/full/backpressure sequence, then drain and pop-on-empty.
        vecs_a.push_back(mk("push0",     0,0,1,32'h00,ins_of(32'h00),0, 2'd1,1,1, 1,32'h00,ins_of(32'h00)));
        vecs_a.push_back(mk("push4",     0,0,1,32'h04,ins_of(32'h04),0, 2'd2,1,0, 1,32'h00,ins_of(32'h00)));
        vecs_a.push_back(mk("full_hold", 0,0,1,32'h08,ins_of(32'h08),0, 2'd2,1,0, 1,32'h00,ins_of(32'h00)));
        vecs_a.push_back(mk("full_pop",  0,0,1,32'h08,ins_of(32'h08),1, 2'd1,1,1, 1,32'h04,ins_of(32'h04)));
        vecs_a.push_back(mk("push8",     0,0,1,32'h08,ins_of(32'h08),0, 2'd2,1,0, 1,32'h04,ins_of(32'h04)));
        vecs_a.push_back(mk("pop4",      0,0,0,32'h0C,ins_of(32'h0C),1, 2'd1,1,1, 1,32'h08,ins_of(32'h08)));
        vecs_a.push_back(mk("pop8",      0,0,0,32'h0C,ins_of(32'h0C),1, 2'd0,0,1, 0,32'h00,32'h00));
        vecs_a.push_back(mk("pop_empty", 0,0,0,32'h0C,ins_of(32'h0C),1, 2'd0,0,1, 0,32'h00,32'h00));

        // Flush with a live input beat, refill, then reset+flush together at full.
        vecs_b.push_back(mk("push20",    0,0,1,32'h20,ins_of(32'h20),0, 2'd1,1,1, 1,32'h20,ins_of(32'h20)));
        vecs_b.push_back(mk("push24",    0,0,1,32'h24,ins_of(32'h24),0, 2'd2,1,0, 1,32'h20,ins_of(32'h20)));
        vecs_b.push_back(mk("flush",     0,1,1,32'h40,ins_of(32'h40),1, 2'd0,0,1, 0,32'h00,32'h00));
        vecs_b.push_back(mk("post_fl",   0,0,1,32'h80,ins_of(32'h80),0, 2'd1,1,1, 1,32'h80,ins_of(32'h80)));
        vecs_b.push_back(mk("push84",    0,0,1,32'h84,ins_of(32'h84),0, 2'd2,1,0, 1,32'h80,ins_of(32'h80)));
        vecs_b.push_back(mk("rst_flush", 1,1,1,32'h88,ins_of(32'h88),1, 2'd0,0,1, 1,32'h00,RST_INSTR));
        vecs_b.push_back(mk("after_rst", 0,0,1,32'h90,ins_of(32'h90),0, 2'd1,1,1, 1,32'h90,ins_of(32'h90)));

        // Hand-written reset: three cycles, then release.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_status("reset", 2'd0, 1'b0, 1'b1);
        check("reset.out_pc",    out_pc,    32'h0);
        check("reset.out_instr", out_instr, RST_INSTR);
        $display("reset released -> level=%0d ov=%0b ir=%0b out_instr=%08h", level, out_valid, in_ready, out_instr);

        foreach (vecs_a[i]) apply(vecs_a[i]);

        // Hand-written streaming: push and pop every cycle, head lags input by one beat.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] pc;
            pc = 32'(k * 4);
            in_valid = 1'b1; in_pc = pc; in_instr = ins_of(pc); out_ready = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("stream%0d.level", k), 32'(level), 32'd1);
            check($sformatf("stream%0d.out_pc", k), out_pc, pc);
            check($sformatf("stream%0d.out_instr", k), out_instr, ins_of(pc));
            $display("stream %0d pc=%08h -> level=%0d out_pc=%08h out_instr=%08h", k, pc, level, out_pc, out_instr);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_status("stream_drain", 2'd0, 1'b0, 1'b1);
        $display("stream drain -> level=%0d ov=%0b", level, out_valid);

        foreach (vecs_b[i]) apply(vecs_b[i]);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
